// File: rtl/seg_chaser_if.sv
// Control and display bundle for the seven-segment perimeter chaser.
// The master drives the animation controls; the slave (the chaser) drives the display.
interface seg_chaser_if #(
    parameter int N_DIGITS = 3
) ();
    localparam int HEAD_W = $clog2(2 * N_DIGITS + 4);

    logic                    enable;
    logic                    dir;
    logic [1:0]              speed;
    logic                    step_pulse;
    logic [7*N_DIGITS-1:0]   hex_out;
    logic [HEAD_W-1:0]       head_pos;
    logic                    wrap;

    modport master (
        output enable, dir, speed, step_pulse,
        input  hex_out, head_pos, wrap
    );

    modport slave (
        input  enable, dir, speed, step_pulse,
        output hex_out, head_pos, wrap
    );
endinterface

// File: rtl/seg_chaser.sv
// Seven-segment chaser: lit segments run around the outer perimeter of a row
// of active-low displays, stepped by a prescaler or by a manual step pulse.
module seg_chaser #(
    parameter int N_DIGITS = 3,
    parameter int PRESCALE = 5_000_000,
    parameter int TAIL     = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    seg_chaser_if.slave  bus
);
    localparam int L      = 2 * N_DIGITS + 4;
    localparam int HEAD_W = $clog2(L);
    localparam int HEX_W  = 7 * N_DIGITS;
    localparam int IDX_W  = $clog2(HEX_W);
    localparam int CNT_W  = $clog2(PRESCALE);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_m1;
    logic              step_q;
    logic              step_prev;
    logic              tick;
    logic              at_wrap;
    logic [HEAD_W-1:0] head;
    logic [HEAD_W-1:0] head_next;
    logic              wrap_q;
    logic [HEX_W-1:0]  hex_q;
    logic [HEX_W-1:0]  hex_next;

    // Map a perimeter position to its bit index in the flat segment vector:
    // tops left-to-right, b/c of the rightmost digit, bottoms right-to-left,
    // then e/f of the leftmost digit.
    function automatic int seg_bit(input int p);
        int idx;
        if (p < N_DIGITS)
            idx = 7 * (N_DIGITS - 1 - p);
        else if (p == N_DIGITS)
            idx = 1;
        else if (p == N_DIGITS + 1)
            idx = 2;
        else if (p <= 2 * N_DIGITS + 1)
            idx = 7 * (p - N_DIGITS - 2) + 3;
        else if (p == 2 * N_DIGITS + 2)
            idx = 7 * (N_DIGITS - 1) + 4;
        else
            idx = 7 * (N_DIGITS - 1) + 5;
        return idx;
    endfunction

    // Step period selection and the single tick source (free-run or manual edge).
    always_comb begin
        period_m1 = CNT_W'((PRESCALE >> bus.speed) - 1);
        tick      = bus.enable ? (cnt >= period_m1) : (step_q && !step_prev);
    end

    // NOTE: state is registered with non-blocking assignments under an async
    // active-low reset so every flop updates from the same pre-edge values.
    // Prescaler: counts only while free-running; >= lets a speed-up fire at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!bus.enable || cnt >= period_m1)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Register the manual step input and keep one cycle of history for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q    <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_q    <= bus.step_pulse;
            step_prev <= step_q;
        end
    end

    // Next head position with explicit wrap at both ends of the perimeter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        at_wrap   = 1'b0;
        head_next = head;
        if (!bus.dir) begin
            at_wrap   = (head == HEAD_W'(L - 1));
            head_next = at_wrap ? '0 : head + HEAD_W'(1);
        end else begin
            at_wrap   = (head == '0);
            head_next = at_wrap ? HEAD_W'(L - 1) : head - HEAD_W'(1);
        end
    end

    // Head register and one-cycle wrap flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            wrap_q <= 1'b0;
        end else begin
            if (tick)
                head <= head_next;
            wrap_q <= tick && at_wrap;
        end
    end

    // Draw head plus trail; the trail lies behind the head for the current direction.
    always_comb begin
        int pos;
        pos      = 0;
        hex_next = '1;
        for (int k = 0; k < TAIL; k++) begin
            pos = bus.dir ? int'(head) + k : int'(head) - k;
            if (pos >= L)
                pos = pos - L;
            else if (pos < 0)
                pos = pos + L;
            hex_next[IDX_W'(seg_bit(pos))] = 1'b0;
        end
    end

    // Display register: blank in reset, one cycle behind head/dir otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hex_q <= '1;
        else
            hex_q <= hex_next;
    end

    assign bus.hex_out  = hex_q;
    assign bus.head_pos = head;
    assign bus.wrap     = wrap_q;
endmodule
